// File: rtl/vector_execute_pipe.sv
// Execute stage with a forwarded scalar ALU path and a multi-beat vector path.
// A valid/ready handshake on both sides; all results and flags are registered.
module vector_execute_pipe #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8,
  parameter int LANES        = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    isvector,
  input  logic [2:0]                              ALUControlE,
  input  logic                                    ALUSrcE,
  input  logic [WIDTH-1:0]                        data1,
  input  logic [WIDTH-1:0]                        data2,
  input  logic [WIDTH-1:0]                        data3,
  input  logic [WIDTH-1:0]                        forwardM,
  input  logic [WIDTH-1:0]                        forwardWB,
  input  logic [1:0]                              data1ForwardSelector,
  input  logic [1:0]                              data2ForwardSelector,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]      A,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]      B,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [WIDTH-1:0]                        ALUResultE,
  output logic [WIDTH-1:0]                        data2AfterForward,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]      Out_v,
  output logic                                    N,
  output logic                                    Z,
  output logic                                    V,
  output logic                                    C,
  output logic                                    busy
);

  localparam int BEATS = VECTOR_WIDTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             n, z, v, c;
  } alu_t;

  function automatic alu_t alu(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    alu_t         o;
    logic [WIDTH:0] wide;
    logic [4:0]   sh;
    o    = '0;
    wide = '0;
    sh   = b[4:0];
    case (op)
      3'b000: begin
        wide = {1'b0, a} + {1'b0, b};
        o.r  = wide[WIDTH-1:0];
        o.c  = wide[WIDTH];
        o.v  = (a[WIDTH-1] == b[WIDTH-1]) && (o.r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        wide = {1'b0, a} - {1'b0, b};
        o.r  = wide[WIDTH-1:0];
        o.c  = ~wide[WIDTH];  // no borrow means a >= b
        o.v  = (a[WIDTH-1] != b[WIDTH-1]) && (o.r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: o.r = a & b;
      3'b011: o.r = a | b;
      3'b100: o.r = a ^ b;
      3'b101: o.r = (int'(sh) >= WIDTH) ? '0 : (a << sh);
      3'b110: o.r = (int'(sh) >= WIDTH) ? '0 : (a >> sh);
      default: o.r = b;
    endcase
    o.n = o.r[WIDTH-1];
    o.z = (o.r == '0);
    return o;
  endfunction

  state_t                               state, state_n;
  logic [BW-1:0]                        beat;
  logic [2:0]                           op_q;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   a_q, b_q;
  logic                                 acc_n, acc_z, acc_v, acc_c;
  logic [WIDTH-1:0]                     fwd1, fwd2;
  alu_t                                 sres;
  alu_t                                 lane_res [LANES];
  logic [IW-1:0]                        lane_idx [LANES];
  logic                                 beat_n, beat_z, beat_v, beat_c;
  logic                                 beat_last, accept;

  always_comb begin
    case (data1ForwardSelector)
      2'b01:   fwd1 = forwardWB;
      2'b10:   fwd1 = forwardM;
      default: fwd1 = data1;
    endcase
    case (data2ForwardSelector)
      2'b01:   fwd2 = forwardWB;
      2'b10:   fwd2 = forwardM;
      default: fwd2 = data2;
    endcase
    sres = alu(ALUControlE, fwd1, ALUSrcE ? data3 : fwd2);
  end

  // Lane l of the current beat handles element beat*LANES + l.
  always_comb begin
    beat_n = 1'b0;
    beat_z = 1'b1;
    beat_v = 1'b0;
    beat_c = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = IW'(int'(beat) * LANES + l);
      lane_res[l] = alu(op_q, a_q[lane_idx[l]], b_q[lane_idx[l]]);
      beat_n      = beat_n | lane_res[l].n;
      beat_z      = beat_z & lane_res[l].z;
      beat_v      = beat_v | lane_res[l].v;
      beat_c      = beat_c | lane_res[l].c;
    end
  end

  assign beat_last = (beat == BW'(BEATS - 1));
  assign accept    = in_valid && in_ready;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = isvector ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (beat_last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = in_valid ? (isvector ? RUN : DONE) : IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Nothing is offered as acceptable while reset is held.
    if (rst) in_ready = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      beat              <= '0;
      op_q              <= '0;
      a_q               <= '0;
      b_q               <= '0;
      acc_n             <= 1'b0;
      acc_z             <= 1'b1;
      acc_v             <= 1'b0;
      acc_c             <= 1'b0;
      ALUResultE        <= '0;
      data2AfterForward <= '0;
      Out_v             <= '0;
      {N, Z, V, C}      <= 4'b0000;
    end else begin
      state <= state_n;
      if (state == RUN) begin
        for (int l = 0; l < LANES; l++) Out_v[lane_idx[l]] <= lane_res[l].r;
        acc_n <= acc_n | beat_n;
        acc_z <= acc_z & beat_z;
        acc_v <= acc_v | beat_v;
        acc_c <= acc_c | beat_c;
        beat  <= beat + 1'b1;
        if (beat_last) begin
          N <= acc_n | beat_n;
          Z <= acc_z & beat_z;
          V <= acc_v | beat_v;
          C <= acc_c | beat_c;
        end
      end
      if (accept) begin
        if (isvector) begin
          a_q   <= A;
          b_q   <= B;
          op_q  <= ALUControlE;
          beat  <= '0;
          Out_v <= '0;
          acc_n <= 1'b0;
          acc_z <= 1'b1;
          acc_v <= 1'b0;
          acc_c <= 1'b0;
        end else begin
          ALUResultE        <= sres.r;
          data2AfterForward <= fwd2;
          {N, Z, V, C}      <= {sres.n, sres.z, sres.v, sres.c};
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_execute_pipe.sv
// Randomized scoreboard bench for vector_execute_pipe: the driver pushes the
// expected output snapshot per accepted op, a monitor compares on out_valid.
module tb_vector_execute_pipe;

  localparam int W  = 24;
  localparam int VW = 8;
  localparam int LN = 2;
  localparam int CW = VW * W;

  typedef logic [VW-1:0][W-1:0] vec_t;

  typedef struct packed {
    logic         vec;
    logic [2:0]   op;
    logic         srcsel;
    logic [W-1:0] d1, d2, d3, fm, fwb;
    logic [1:0]   s1, s2;
    vec_t         a, b;
  } op_t;

  typedef struct packed {
    logic [W-1:0] alu, d2;
    vec_t         outv;
    logic         n, z, v, c;
  } exp_t;

  logic         clk, rst;
  logic         in_valid, in_ready, isvector, ALUSrcE, out_valid, out_ready;
  logic [2:0]   ALUControlE;
  logic [W-1:0] data1, data2, data3, forwardM, forwardWB, ALUResultE, data2AfterForward;
  logic [1:0]   data1ForwardSelector, data2ForwardSelector;
  vec_t         A, B, Out_v;
  logic         N, Z, V, C, busy;

  vector_execute_pipe #(.WIDTH(W), .VECTOR_WIDTH(VW), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .isvector(isvector),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .data1(data1), .data2(data2), .data3(data3),
    .forwardM(forwardM), .forwardWB(forwardWB), .data1ForwardSelector(data1ForwardSelector),
    .data2ForwardSelector(data2ForwardSelector), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResultE(ALUResultE), .data2AfterForward(data2AfterForward),
    .Out_v(Out_v), .N(N), .Z(Z), .V(V), .C(C), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t m;  // reference view of every registered output

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the arithmetic definitions, using wide signed integers.
  task automatic ref_alu(input logic [2:0] op, input longint a, input longint b,
                         output longint r, output bit n, output bit z, output bit v, output bit c);
    longint mask, sa, sb, full, sfull, sh;
    mask = (longint'(1) << W) - 1;
    sa   = (a >= (longint'(1) << (W - 1))) ? a - (longint'(1) << W) : a;
    sb   = (b >= (longint'(1) << (W - 1))) ? b - (longint'(1) << W) : b;
    sh   = b % 32;
    v = 0; c = 0; full = 0; sfull = 0;
    case (op)
      3'd0: begin full = a + b; sfull = sa + sb; r = full & mask; c = (full > mask); end
      3'd1: begin sfull = sa - sb; r = (a - b) & mask; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sh >= W) ? 0 : ((a << sh) & mask);
      3'd6: r = (sh >= W) ? 0 : (a >> sh);
      default: r = b;
    endcase
    if (op <= 3'd1)
      v = (sfull > (longint'(1) << (W - 1)) - 1) || (sfull < -(longint'(1) << (W - 1)));
    n = (r >= (longint'(1) << (W - 1)));
    z = (r == 0);
  endtask

  function automatic logic [W-1:0] fwd(input logic [1:0] s, input logic [W-1:0] d,
                                       input logic [W-1:0] fm, input logic [W-1:0] fwb);
    return (s == 2'b01) ? fwb : (s == 2'b10) ? fm : d;
  endfunction

  task automatic model(input op_t o);
    longint r;
    bit n, z, v, c;
    if (o.vec) begin
      m.n = 0; m.z = 1; m.v = 0; m.c = 0;
      for (int i = 0; i < VW; i++) begin
        ref_alu(o.op, longint'(o.a[i]), longint'(o.b[i]), r, n, z, v, c);
        m.outv[i] = W'(r);
        m.n |= n; m.z &= z; m.v |= v; m.c |= c;
      end
    end else begin
      logic [W-1:0] f1, f2;
      f1 = fwd(o.s1, o.d1, o.fm, o.fwb);
      f2 = fwd(o.s2, o.d2, o.fm, o.fwb);
      ref_alu(o.op, longint'(f1), longint'(o.srcsel ? o.d3 : f2), r, n, z, v, c);
      m.alu = W'(r);
      m.d2  = f2;
      {m.n, m.z, m.v, m.c} = {n, z, v, c};
    end
    sbq.push_back(m);
  endtask

  // Offer an op until accepted; in_valid stays high until the caller lowers it.
  task automatic drive_op(input op_t o, input bit ordy);
    bit acc = 0;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin
        isvector = o.vec; ALUControlE = o.op; ALUSrcE = o.srcsel;
        data1 = o.d1; data2 = o.d2; data3 = o.d3; forwardM = o.fm; forwardWB = o.fwb;
        data1ForwardSelector = o.s1; data2ForwardSelector = o.s2; A = o.a; B = o.b;
        out_ready = ordy;
      end else begin
        out_ready = ($urandom % 4) != 0;
      end
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        acc = 1;
        model(o);
      end
    end
    if (!acc) check("accept_timeout", in_ready, 1);
  endtask

  task automatic idle_cycle();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    bit seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      idle_cycle(); #2;
      seen = out_valid;
    end
    if (!seen) check("out_valid_timeout", out_valid, 1);
  endtask

  function automatic op_t rand_op(input bit vec);
    op_t o;
    o.vec = vec; o.op = 3'($urandom); o.srcsel = 1'($urandom);
    o.d1 = W'($urandom); o.d2 = W'($urandom); o.d3 = W'($urandom);
    o.fm = W'($urandom); o.fwb = W'($urandom);
    o.s1 = 2'($urandom); o.s2 = 2'($urandom);
    for (int i = 0; i < VW; i++) begin
      o.a[i] = W'($urandom);
      o.b[i] = ($urandom % 8 == 0) ? o.a[i] : W'($urandom);
    end
    return o;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ALUResultE"}, ALUResultE, 0);
    check({tag, "_data2AfterForward"}, data2AfterForward, 0);
    check({tag, "_Out_v"}, Out_v, 0);
    check({tag, "_NZVC"}, {N, Z, V, C}, 0);
  endtask

  // Monitor: compares the oldest expected snapshot whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!rst && out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          e = sbq[0];
          check("ALUResultE", ALUResultE, e.alu);
          check("data2AfterForward", data2AfterForward, e.d2);
          check("Out_v", Out_v, e.outv);
          check("NZVC", {N, Z, V, C}, {e.n, e.z, e.v, e.c});
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    logic [W-1:0] saved_alu;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; isvector = 1'b0; ALUControlE = '0;
    ALUSrcE = 1'b0; data1 = '0; data2 = '0; data3 = '0; forwardM = '0; forwardWB = '0;
    data1ForwardSelector = '0; data2ForwardSelector = '0; A = '0; B = '0;
    m = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #3 check_all_zero("reset");
    @(negedge clk); #1 rst = 1'b0;
    #1 check("in_ready_after_release", in_ready, 1);

    // Scalar add with forwardM on operand 1
    o = '0; o.d1 = 24'h123456; o.s1 = 2'b10; o.fm = 24'h000005; o.d2 = 24'h000003;
    drive_op(o, 1'b1);
    idle_cycle(); #2;
    check("scalar_latency_out_valid", out_valid, 1);
    check("scalar_add_result", ALUResultE, 24'h000008);
    check("scalar_add_nzvc", {N, Z, V, C}, 4'b0000);
    check("scalar_add_d2", data2AfterForward, 24'h000003);
    idle_cycle();

    // Vector add held by backpressure after completion
    o = '0; o.vec = 1'b1; o.op = 3'b000;
    for (int i = 0; i < VW; i++) begin o.a[i] = W'(i); o.b[i] = 24'hFFFFFF; end
    drive_op(o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle_cycle(); #2;
      check("vec_run_busy", busy, 1);
      check("vec_run_in_ready", in_ready, 0);
      check("vec_run_out_valid", out_valid, 0);
    end
    @(negedge clk); #3;
    check("vec_latency_out_valid", out_valid, 1);
    check("vec_add_elem0", Out_v[0], 24'hFFFFFF);
    check("vec_add_elem7", Out_v[7], 24'h000006);
    check("vec_add_nzvc", {N, Z, V, C}, 4'b1001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #3;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end

    // Scalar sub overflow accepted on the edge out_ready rises
    o = '0; o.op = 3'b001; o.d1 = 24'h800000; o.srcsel = 1'b1; o.d3 = 24'h000001;
    drive_op(o, 1'b1);
    idle_cycle(); #2;
    check("sub_out_valid", out_valid, 1);
    check("sub_result", ALUResultE, 24'h7FFFFF);
    check("sub_nzvc", {N, Z, V, C}, 4'b0011);
    idle_cycle();

    // Reset in the middle of a vector op
    drive_op(rand_op(1'b1), 1'b1);
    idle_cycle(); idle_cycle();
    @(negedge clk); #1 rst = 1'b1;
    #1 check_all_zero("mid_op_reset");
    sbq.delete();
    m = '0;
    idle_cycle();
    @(negedge clk); #1 rst = 1'b0;
    #1 check("in_ready_after_mid_reset", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      idle_cycle(); #2;
      check("no_out_valid_after_reset", out_valid, 0);
    end

    // Vector xor with A==B leaves the scalar result untouched
    drive_op(rand_op(1'b0), 1'b1);
    wait_out_valid();
    saved_alu = m.alu;
    o = rand_op(1'b1); o.op = 3'b100; o.b = o.a;
    drive_op(o, 1'b1);
    wait_out_valid();
    check("xor_out_v_zero", Out_v, 0);
    check("xor_nzvc", {N, Z, V, C}, 4'b0100);
    check("xor_alu_unchanged", ALUResultE, saved_alu);

    // Random mix with random backpressure
    for (int k = 0; k < 60; k++) begin
      drive_op(rand_op(($urandom % 10) < 3), ($urandom % 4) != 0);
      if ($urandom % 3 == 0) idle_cycle();
    end

    for (int t = 0; t < 200 && sbq.size() != 0; t++) begin
      @(negedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk); #4;
    check("drain_queue_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
